// File: rtl/dac_interp_pkg.sv
// ---------------------------------------------------------------------------
// dac_interp_pkg
//   Shared widths and FSM encoding for the DAC-side linear interpolator.
//   DA_INTERP_NBIT tracks the ADC averaging width by default, so the DAC
//   up-conversion ratio mirrors the ADC decimation ratio.
// ---------------------------------------------------------------------------
package dac_interp_pkg;

  localparam int DA_DATA_NBIT    = 12;  // unsigned DAC code width
  localparam int DA_AVG_NUM_NBIT = 3;   // log2 of the ADC averaging ratio
  localparam int DA_INTERP_NBIT  = DA_AVG_NUM_NBIT;

  typedef enum logic [1:0] {
    DI_IDLE   = 2'd0,  // no sample seen since reset
    DI_RUN    = 2'd1,  // interpolating P -> C
    DI_STARVE = 2'd2   // segment ended with nothing queued; hold C
  } di_state_t;

endpackage

// File: rtl/dac_lerp.sv
// ---------------------------------------------------------------------------
// dac_lerp
//   Combinational linear interpolation between two unsigned codes:
//     y = p + floor((c - p) * k / 2**INTERP_NBIT)
//   Kept separate so a DSP-based multiplier can replace it later.
// Ports:
//   p  segment start code
//   c  segment target code
//   k  phase, 0 .. 2**INTERP_NBIT-1
//   y  interpolated code (always between p and c, so it never wraps)
// ---------------------------------------------------------------------------
module dac_lerp
  import dac_interp_pkg::*;
#(
  parameter int DATA_NBIT   = DA_DATA_NBIT,
  parameter int INTERP_NBIT = DA_INTERP_NBIT
) (
  input  logic [DATA_NBIT-1:0]   p,
  input  logic [DATA_NBIT-1:0]   c,
  input  logic [INTERP_NBIT-1:0] k,
  output logic [DATA_NBIT-1:0]   y
);

  localparam int PW = DATA_NBIT + 1 + INTERP_NBIT;

  logic signed [DATA_NBIT:0] diff;
  logic signed [PW-1:0]      diff_ext;
  logic signed [PW-1:0]      k_ext;
  logic signed [PW-1:0]      prod;
  logic signed [PW-1:0]      shifted;
  logic        [PW-1:0]      sum;
  logic                      lerp_unused;

  // One extra bit makes the unsigned difference a correct signed value.
  assign diff     = $signed({1'b0, c} - {1'b0, p});
  assign diff_ext = {{INTERP_NBIT{diff[DATA_NBIT]}}, diff};
  assign k_ext    = {{(DATA_NBIT + 1){1'b0}}, k};
  assign prod     = diff_ext * k_ext;
  // Arithmetic shift floors toward -inf, so descending ramps step evenly.
  assign shifted  = prod >>> INTERP_NBIT;
  assign sum      = {{(INTERP_NBIT + 1){1'b0}}, p} + shifted;
  assign y        = sum[DATA_NBIT-1:0];

  // Upper bits are zero by construction (result lies between p and c).
  assign lerp_unused = ^sum[PW-1:DATA_NBIT];

endmodule

// File: rtl/dac_interp.sv
// ---------------------------------------------------------------------------
// dac_interp
//   DAC-side sample-rate up-converter. Each accepted input code becomes the
//   target of a segment of 2**INTERP_NBIT linearly interpolated output
//   codes, one per i_tick from the DAC serializer.
// Ports:
//   clk, rst_n   single clock domain, asynchronous active-low reset
//   i_strobe     input sample valid (single cycle), i_data sampled with it
//   o_ready      holding register empty; a strobe this cycle is accepted
//   i_tick       output pacing pulse (spacing >= 2 clocks)
//   i_clr_err    clears o_underrun / o_overflow (a new event wins)
//   o_strobe     output valid, one cycle after the tick
//   o_data       interpolated code, held between strobes
//   o_underrun   sticky: segment ended with no next sample
//   o_overflow   sticky: strobe arrived while o_ready=0 (sample dropped)
// ---------------------------------------------------------------------------
module dac_interp
  import dac_interp_pkg::*;
#(
  parameter int DATA_NBIT   = DA_DATA_NBIT,
  parameter int INTERP_NBIT = DA_INTERP_NBIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_strobe,
  input  logic [DATA_NBIT-1:0] i_data,
  output logic                 o_ready,
  input  logic                 i_tick,
  input  logic                 i_clr_err,
  output logic                 o_strobe,
  output logic [DATA_NBIT-1:0] o_data,
  output logic                 o_underrun,
  output logic                 o_overflow
);

  localparam logic [INTERP_NBIT-1:0] K_ONE = INTERP_NBIT'(1);

  di_state_t              state, state_nxt;
  logic [DATA_NBIT-1:0]   p, p_nxt;
  logic [DATA_NBIT-1:0]   c, c_nxt;
  logic [DATA_NBIT-1:0]   h_data, h_data_nxt;
  logic                   h_valid, h_valid_nxt;
  logic [INTERP_NBIT-1:0] k, k_nxt;
  logic                   strobe_nxt;
  logic [DATA_NBIT-1:0]   data_nxt;
  logic                   underrun_set;
  logic                   seg_end;
  logic                   drop;
  logic [DATA_NBIT-1:0]   lerp_y;

  dac_lerp #(
    .DATA_NBIT  (DATA_NBIT),
    .INTERP_NBIT(INTERP_NBIT)
  ) u_lerp (
    .p(p),
    .c(c),
    .k(k),
    .y(lerp_y)
  );

  assign o_ready = ~h_valid;
  assign drop    = i_strobe & h_valid;
  assign seg_end = (state == DI_RUN) & i_tick & (&k);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch; blocking '=' is correct in
  // combinational logic, while the register block below uses '<=' only.
  always_comb begin
    state_nxt    = state;
    p_nxt        = p;
    c_nxt        = c;
    h_data_nxt   = h_data;
    h_valid_nxt  = h_valid;
    k_nxt        = k;
    strobe_nxt   = 1'b0;
    data_nxt     = o_data;
    underrun_set = 1'b0;

    unique case (state)
      DI_IDLE: begin
        // First sample starts a flat segment; ticks are ignored here.
        if (i_strobe) begin
          p_nxt     = i_data;
          c_nxt     = i_data;
          k_nxt     = '0;
          state_nxt = DI_RUN;
        end
      end

      DI_RUN: begin
        if (i_tick) begin
          strobe_nxt = 1'b1;
          data_nxt   = lerp_y;
          k_nxt      = k + K_ONE;  // wraps to 0 at segment end
        end
        if (seg_end) begin
          p_nxt = c;
          if (h_valid) begin
            c_nxt       = h_data;
            h_valid_nxt = 1'b0;
          end else if (i_strobe) begin
            // Sample lands exactly at the boundary: use it directly.
            c_nxt = i_data;
          end else begin
            state_nxt    = DI_STARVE;
            underrun_set = 1'b1;
          end
        end else if (i_strobe && !h_valid) begin
          h_data_nxt  = i_data;
          h_valid_nxt = 1'b1;
        end
      end

      DI_STARVE: begin
        // Tick emits the old target even if a sample arrives this cycle.
        if (i_tick) begin
          strobe_nxt = 1'b1;
          data_nxt   = c;
        end
        if (i_strobe) begin
          p_nxt     = c;
          c_nxt     = i_data;
          k_nxt     = '0;
          state_nxt = DI_RUN;
        end
      end

      default: state_nxt = DI_IDLE;
    endcase
  end

  // NOTE: the holding register is a single word, not a memory array, so it
  // is reset along with the rest; that keeps o_data deterministic after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DI_IDLE;
      p          <= '0;
      c          <= '0;
      h_data     <= '0;
      h_valid    <= 1'b0;
      k          <= '0;
      o_strobe   <= 1'b0;
      o_data     <= '0;
      o_underrun <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      p          <= p_nxt;
      c          <= c_nxt;
      h_data     <= h_data_nxt;
      h_valid    <= h_valid_nxt;
      k          <= k_nxt;
      o_strobe   <= strobe_nxt;
      o_data     <= data_nxt;
      // Set has priority over clear.
      o_underrun <= underrun_set | (o_underrun & ~i_clr_err);
      o_overflow <= drop | (o_overflow & ~i_clr_err);
    end
  end

endmodule

// File: tb/tb_dac_interp.sv
// ---------------------------------------------------------------------------
// tb_dac_interp
//   Directed bench for dac_interp (DATA_NBIT=12, INTERP_NBIT=3). Each tick
//   that should produce output pushes its expected code into a queue; a
//   negedge monitor pops and compares on every o_strobe.
// ---------------------------------------------------------------------------
module tb_dac_interp;

  localparam int DW = 12;
  localparam int KW = 3;
  localparam int R  = 8;

  logic          clk;
  logic          rst_n;
  logic          i_strobe;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          i_tick;
  logic          i_clr_err;
  logic          o_strobe;
  logic [DW-1:0] o_data;
  logic          o_underrun;
  logic          o_overflow;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];

  dac_interp #(
    .DATA_NBIT  (DW),
    .INTERP_NBIT(KW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_strobe  (i_strobe),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .i_tick    (i_tick),
    .i_clr_err (i_clr_err),
    .o_strobe  (o_strobe),
    .o_data    (o_data),
    .o_underrun(o_underrun),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Floor interpolation written as explicit ceiling-of-negation for the
  // negative case, independent of any shift semantics.
  function automatic int lerp_ref(input int p, input int c, input int k);
    int prod;
    prod = (c - p) * k;
    if (prod >= 0) return p + prod / R;
    else           return p - ((-prod + R - 1) / R);
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && o_strobe) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe_queue_size", 32'(exp_q.size()), 32'd1);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("o_data", 32'(o_data), 32'(e));
      end
    end
  end

  task automatic send(input int d);
    @(negedge clk);
    i_strobe = 1'b1;
    i_data   = DW'(d);
    @(negedge clk);
    i_strobe = 1'b0;
  endtask

  task automatic tick(input int e);
    exp_q.push_back(e);
    @(negedge clk);
    i_tick = 1'b1;
    @(negedge clk);
    i_tick = 1'b0;
  endtask

  task automatic tick_idle();
    @(negedge clk);
    i_tick = 1'b1;
    @(negedge clk);
    i_tick = 1'b0;
  endtask

  task automatic tick_send(input int e, input int d);
    exp_q.push_back(e);
    @(negedge clk);
    i_tick   = 1'b1;
    i_strobe = 1'b1;
    i_data   = DW'(d);
    @(negedge clk);
    i_tick   = 1'b0;
    i_strobe = 1'b0;
  endtask

  task automatic clr_pulse(input logic with_strobe, input int d);
    @(negedge clk);
    i_clr_err = 1'b1;
    i_strobe  = with_strobe;
    i_data    = DW'(d);
    @(negedge clk);
    i_clr_err = 1'b0;
    i_strobe  = 1'b0;
  endtask

  task automatic run_seg(input int p, input int c);
    for (int k = 0; k < R; k++) tick(lerp_ref(p, c, k));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1[R] = '{100, 110, 120, 130, 140, 150, 160, 170};
    int t2[R] = '{200, 199, 198, 197, 196, 195, 194, 193};
    int t5[R] = '{0, 511, 1023, 1535, 2047, 2559, 3071, 3583};

    rst_n     = 1'b0;
    i_strobe  = 1'b0;
    i_data    = '0;
    i_tick    = 1'b0;
    i_clr_err = 1'b0;

    // Reset state.
    #12;
    check("rst_o_ready",    32'(o_ready),    32'd1);
    check("rst_o_strobe",   32'(o_strobe),   32'd0);
    check("rst_o_data",     32'(o_data),     32'd0);
    check("rst_o_underrun", 32'(o_underrun), 32'd0);
    check("rst_o_overflow", 32'(o_overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores ticks.
    tick_idle();
    tick_idle();

    // 1. Flat first segment, ramp 100->180, then starve.
    send(100);
    check("t1_ready_after_first", 32'(o_ready), 32'd1);
    send(180);
    check("t1_ready_h_full", 32'(o_ready), 32'd0);
    for (int i = 0; i < R; i++) tick(100);
    for (int i = 0; i < R; i++) tick(t1[i]);
    check("t1_underrun", 32'(o_underrun), 32'd1);
    check("t1_ready_starve", 32'(o_ready), 32'd1);
    tick(180);
    tick(180);

    // 2/3. Segment 180->200, then 200->193 with overflow checks first.
    send(200);
    send(193);
    run_seg(180, 200);
    send(250);
    check("t3_ready_h_full", 32'(o_ready), 32'd0);
    send(555);
    check("t3_overflow_set", 32'(o_overflow), 32'd1);
    clr_pulse(1'b0, 0);
    check("t3_overflow_cleared", 32'(o_overflow), 32'd0);
    check("t3_underrun_cleared", 32'(o_underrun), 32'd0);
    clr_pulse(1'b1, 555);
    check("t3_set_wins_over_clr", 32'(o_overflow), 32'd1);
    clr_pulse(1'b0, 0);
    check("t3_overflow_cleared2", 32'(o_overflow), 32'd0);
    for (int i = 0; i < R; i++) tick(t2[i]);

    // 4. Segment 193->250; sample 300 arrives on the k=7 tick.
    for (int k = 0; k < R - 1; k++) tick(lerp_ref(193, 250, k));
    tick_send(lerp_ref(193, 250, R - 1), 300);
    check("t4_no_underrun", 32'(o_underrun), 32'd0);
    check("t4_no_overflow", 32'(o_overflow), 32'd0);
    check("t4_ready", 32'(o_ready), 32'd1);
    run_seg(250, 300);
    check("t4_underrun_after", 32'(o_underrun), 32'd1);

    // 5. Segment 300->0, full-scale 0->4095, STARVE exit with 4000.
    send(0);
    send(4095);
    run_seg(300, 0);
    for (int i = 0; i < R; i++) tick(t5[i]);
    tick(4095);
    tick_send(4095, 4000);
    tick(4095);
    tick(lerp_ref(4095, 4000, 1));
    tick(lerp_ref(4095, 4000, 2));
    drain();

    // 6. Asynchronous reset mid-segment, off the clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_o_data",     32'(o_data),     32'd0);
    check("t6_o_ready",    32'(o_ready),    32'd1);
    check("t6_o_strobe",   32'(o_strobe),   32'd0);
    check("t6_o_underrun", 32'(o_underrun), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick_idle();
    tick_idle();
    tick_idle();
    check("t6_data_after_idle_ticks", 32'(o_data), 32'd0);
    send(42);
    tick(42);
    tick(42);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
